pwm_level_decoder: RTL and testbench

PWM_LEVEL_DECODER -- requirements
Module: pwm_level_decoder

---
 rtl/pwm_level_decoder_pkg.sv | 23 ++
 rtl/pwm_level_decoder_sync_edge.sv | 32 +++
 rtl/pwm_level_decoder.sv | 166 ++++++++++++++++
 tb/tb_pwm_level_decoder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_level_decoder_pkg.sv
// Shared types and constants for the PWM level decoder: FSM states, trend codes
// and the default frame length.
package pwm_level_decoder_pkg;

  localparam int DEFAULT_PERIOD = 16;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam logic [1:0] TREND_FLAT = 2'b00;
  localparam logic [1:0] TREND_RISE = 2'b01;
  localparam logic [1:0] TREND_FALL = 2'b10;

  function automatic logic [1:0] trend_of(input int unsigned cur, input int unsigned prev);
    if (cur > prev) return TREND_RISE;
    if (cur < prev) return TREND_FALL;
    return TREND_FLAT;
  endfunction

endpackage

// File: rtl/pwm_level_decoder_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM input, plus one extra flop so
// a rising edge of the synchronized value can be flagged.
module pwm_level_decoder_sync_edge (
  input  logic clk_div_i,
  input  logic rst_i,
  input  logic async_i,
  output logic s_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic sync_dly_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk_div_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
    end else begin
      meta_q     <= async_i;
      sync_q     <= meta_q;
      sync_dly_q <= sync_q;
    end
  end

  assign s_o    = sync_q;
  assign rise_o = sync_q & ~sync_dly_q;

endmodule

// File: rtl/pwm_level_decoder.sv
// Frame-aligns a PWM stream, decodes the brightness of each frame once locked,
// and reports the breathing trend and direction reversals.
module pwm_level_decoder
  import pwm_level_decoder_pkg::*;
#(
  parameter int PERIOD      = DEFAULT_PERIOD,
  parameter int SYNC_FRAMES = 2
) (
  input  logic                        clk_div_i,
  input  logic                        rst_i,
  input  logic                        pwm_i,
  output logic [$clog2(PERIOD)-1:0]   level_o,
  output logic                        level_valid_o,
  output logic [1:0]                  trend_o,
  output logic                        turn_o,
  output logic                        locked_o,
  output logic                        err_o
);

  localparam int LW = $clog2(PERIOD);
  localparam logic [LW-1:0] CNT_LAST  = LW'(PERIOD - 1);
  localparam logic [2:0]    GOOD_LAST = 3'(SYNC_FRAMES - 1);

  logic s;
  logic rise;

  state_e        state_q,  state_d;
  logic [LW-1:0] cnt_q,    cnt_d;
  logic [LW:0]   high_q,   high_d;
  logic [2:0]    good_q,   good_d;
  logic          first_q,  first_d;
  logic [1:0]    dir_q,    dir_d;
  logic [LW-1:0] level_q,  level_d;
  logic [1:0]    trend_q,  trend_d;
  logic          valid_q,  valid_d;
  logic          turn_q,   turn_d;
  logic          locked_q, locked_d;
  logic          err_q,    err_d;

  logic          fault;
  logic [1:0]    new_trend;
  logic [LW-1:0] level_new;

  pwm_level_decoder_sync_edge u_sync_edge (
    .clk_div_i (clk_div_i),
    .rst_i     (rst_i),
    .async_i   (pwm_i),
    .s_o       (s),
    .rise_o    (rise)
  );

  // A full-high frame counts PERIOD, whose low bits are zero; minus one wraps to PERIOD-1.
  assign level_new = high_q[LW-1:0] - LW'(1);

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    high_d    = high_q;
    good_d    = good_q;
    first_d   = first_q;
    dir_d     = dir_q;
    level_d   = level_q;
    trend_d   = trend_q;
    locked_d  = locked_q;
    valid_d   = 1'b0;
    turn_d    = 1'b0;
    err_d     = 1'b0;
    fault     = 1'b0;
    new_trend = TREND_FLAT;

    case (state_q)
      ST_HUNT: begin
        if (rise) begin
          state_d = ST_MEASURE;
          cnt_d   = LW'(1);
          high_d  = (LW+1)'(1);
          good_d  = '0;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          if (rise) begin
            fault = 1'b1;
          end else begin
            high_d = high_q + {{LW{1'b0}}, s};
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + LW'(1);
          end
        end else if (!s) begin
          fault = 1'b1;
        end else begin
          // Frame boundary with a valid start: close the old frame, open the next.
          cnt_d  = LW'(1);
          high_d = (LW+1)'(1);
          if (state_q == ST_MEASURE) begin
            if (good_q == GOOD_LAST) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              first_d  = 1'b1;
            end else begin
              good_d = good_q + 3'd1;
            end
          end else begin
            new_trend = first_q ? TREND_FLAT : trend_of(32'(level_new), 32'(level_q));
            level_d   = level_new;
            trend_d   = new_trend;
            valid_d   = 1'b1;
            first_d   = 1'b0;
            if (new_trend != TREND_FLAT) begin
              dir_d  = new_trend;
              turn_d = (dir_q != TREND_FLAT) && (dir_q != new_trend);
            end
          end
        end
      end
    endcase

    if (fault) begin
      state_d  = ST_HUNT;
      cnt_d    = '0;
      high_d   = '0;
      err_d    = 1'b1;
      locked_d = 1'b0;
      dir_d    = TREND_FLAT;
    end
  end

  always_ff @(posedge clk_div_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_HUNT;
      cnt_q    <= '0;
      high_q   <= '0;
      good_q   <= '0;
      first_q  <= 1'b0;
      dir_q    <= TREND_FLAT;
      level_q  <= '0;
      trend_q  <= TREND_FLAT;
      valid_q  <= 1'b0;
      turn_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      good_q   <= good_d;
      first_q  <= first_d;
      dir_q    <= dir_d;
      level_q  <= level_d;
      trend_q  <= trend_d;
      valid_q  <= valid_d;
      turn_q   <= turn_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign level_o       = level_q;
  assign level_valid_o = valid_q;
  assign trend_o       = trend_q;
  assign turn_o        = turn_q;
  assign locked_o      = locked_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_pwm_level_decoder.sv
// Self-checking bench: a PERIOD=16/SYNC=2 and a PERIOD=4/SYNC=1 decoder run side
// by side against a frame-level reference model, plus table and scenario checks.
module tb_pwm_level_decoder;

  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm16 = 1'b0;
  logic pwm4  = 1'b0;

  logic [3:0] level16;
  logic [1:0] trend16;
  logic       valid16, turn16, locked16, err16;
  logic [1:0] level4;
  logic [1:0] trend4;
  logic       valid4, turn4, locked4, err4;

  always #5 clk = ~clk;

  pwm_level_decoder #(.PERIOD(16), .SYNC_FRAMES(2)) dut16 (
    .clk_div_i(clk), .rst_i(rst), .pwm_i(pwm16),
    .level_o(level16), .level_valid_o(valid16), .trend_o(trend16),
    .turn_o(turn16), .locked_o(locked16), .err_o(err16)
  );

  pwm_level_decoder #(.PERIOD(4), .SYNC_FRAMES(1)) dut4 (
    .clk_div_i(clk), .rst_i(rst), .pwm_i(pwm4),
    .level_o(level4), .level_valid_o(valid4), .trend_o(trend4),
    .turn_o(turn4), .locked_o(locked4), .err_o(err4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit p_hist [2][MAXE];
  int ecnt = 0;
  int live_from = 0;
  int per [2] = '{16, 4};
  int sfr [2] = '{2, 1};
  int m_mode [2];    // 0 hunt, 1 measure, 2 locked
  int m_fstart [2];
  int m_good [2];
  int m_prev [2];
  int m_dir [2];     // 0 none, 1 rising, 2 falling
  bit m_first [2];
  int e_level [2];
  int e_trend [2];
  bit e_valid [2], e_turn [2], e_locked [2], e_err [2];

  // Synchronized value seen by the decoder at edge e: the input two edges earlier,
  // zero while that sample predates the last reset release.
  function automatic int s_at(input int k, input int e);
    if (e - 2 < live_from || e - 2 >= MAXE) return 0;
    return int'(p_hist[k][e-2]);
  endfunction

  task automatic model_reset(input int k);
    m_mode[k] = 0; m_fstart[k] = 0; m_good[k] = 0; m_prev[k] = 0; m_dir[k] = 0;
    m_first[k] = 0; e_level[k] = 0; e_trend[k] = 0;
    e_valid[k] = 0; e_turn[k] = 0; e_locked[k] = 0; e_err[k] = 0;
  endtask

  task automatic model_step(input int k, input int e);
    int s, sd, h, lvl, t;
    bit fault;
    e_valid[k] = 0; e_turn[k] = 0; e_err[k] = 0; fault = 0;
    s  = s_at(k, e);
    sd = s_at(k, e - 1);
    if (m_mode[k] == 0) begin
      if (s == 1 && sd == 0) begin
        m_mode[k] = 1; m_fstart[k] = e; m_good[k] = 0;
      end
    end else if (e - m_fstart[k] < per[k]) begin
      if (s == 1 && sd == 0) fault = 1;
    end else if (s == 0) begin
      fault = 1;
    end else begin
      h = 0;
      for (int i = m_fstart[k]; i < m_fstart[k] + per[k]; i++) h += s_at(k, i);
      lvl = h - 1;
      if (m_mode[k] == 1) begin
        m_good[k]++;
        if (m_good[k] == sfr[k]) begin
          m_mode[k] = 2; e_locked[k] = 1; m_first[k] = 1;
        end
      end else begin
        t = m_first[k] ? 0 : (lvl > m_prev[k]) ? 1 : (lvl < m_prev[k]) ? 2 : 0;
        e_level[k] = lvl; e_trend[k] = t; e_valid[k] = 1;
        e_turn[k]  = (t != 0 && m_dir[k] != 0 && t != m_dir[k]);
        if (t != 0) m_dir[k] = t;
        m_prev[k] = lvl; m_first[k] = 0;
      end
      m_fstart[k] = e;
    end
    if (fault) begin
      e_err[k] = 1; e_locked[k] = 0; m_mode[k] = 0; m_dir[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (ecnt < MAXE) begin
      p_hist[0][ecnt] = pwm16;
      p_hist[1][ecnt] = pwm4;
    end
    if (rst) begin
      model_reset(0); model_reset(1);
      live_from = ecnt + 1;
    end else begin
      model_step(0, ecnt);
      model_step(1, ecnt);
    end
    ecnt++;
  end

  // ---------------- table vectors ----------------
  typedef struct {
    int high;
    bit exp_v;
    int lvl;
    int trd;
    bit trn;
  } vec_t;

  vec_t vec_a[$];
  vec_t vec_b[$];
  vec_t tbl_q[$];
  bit   tbl_on = 0;

  int n_valid16 = 0, n_err16 = 0, n_valid4 = 0;
  int last_lvl16 = 0;
  int err_locked_snap = 0, err_level_snap = 0;

  // Per-cycle comparison against the model, strobe bookkeeping and table scoring.
  always @(negedge clk) begin
    vec_t v;
    check("d16_level",  level16,  rst ? 0 : e_level[0]);
    check("d16_trend",  trend16,  rst ? 0 : e_trend[0]);
    check("d16_valid",  valid16,  rst ? 0 : int'(e_valid[0]));
    check("d16_turn",   turn16,   rst ? 0 : int'(e_turn[0]));
    check("d16_locked", locked16, rst ? 0 : int'(e_locked[0]));
    check("d16_err",    err16,    rst ? 0 : int'(e_err[0]));
    check("d4_level",   level4,   rst ? 0 : e_level[1]);
    check("d4_trend",   trend4,   rst ? 0 : e_trend[1]);
    check("d4_valid",   valid4,   rst ? 0 : int'(e_valid[1]));
    check("d4_turn",    turn4,    rst ? 0 : int'(e_turn[1]));
    check("d4_locked",  locked4,  rst ? 0 : int'(e_locked[1]));
    check("d4_err",     err4,     rst ? 0 : int'(e_err[1]));
    if (!rst) begin
      if (valid16) begin
        n_valid16++;
        last_lvl16 = int'(level16);
        if (tbl_on) begin
          if (tbl_q.size() == 0) begin
            check("tbl_extra_strobe", tbl_q.size(), 1);
          end else begin
            v = tbl_q.pop_front();
            check("tbl_level", level16, v.lvl);
            check("tbl_trend", trend16, v.trd);
            check("tbl_turn",  turn16,  int'(v.trn));
          end
        end
      end
      if (err16) begin
        n_err16++;
        err_locked_snap = int'(locked16);
        err_level_snap  = int'(level16);
      end
      if (valid4) n_valid4++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive16(input logic v);
    @(posedge clk);
    #1 pwm16 = v;
  endtask

  task automatic send_pat16(input logic [15:0] pat);
    for (int i = 0; i < 16; i++) drive16(pat[i]);
  endtask

  task automatic send_frame16(input int h);
    for (int i = 0; i < 16; i++) drive16(i < h);
  endtask

  task automatic do_reset(input bit check_now);
    @(posedge clk);
    #1 rst = 1'b1;
    if (check_now) begin
      #1;
      check("rst_now_level",  level16,  0);
      check("rst_now_trend",  trend16,  0);
      check("rst_now_valid",  valid16,  0);
      check("rst_now_turn",   turn16,   0);
      check("rst_now_locked", locked16, 0);
      check("rst_now_err",    err16,    0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_table(input vec_t vecs[$]);
    do_reset(0);
    tbl_on = 1;
    foreach (vecs[i]) begin
      if (vecs[i].exp_v) tbl_q.push_back(vecs[i]);
      send_frame16(vecs[i].high);
    end
    repeat (20) drive16(1'b0);
    tbl_on = 0;
    check("tbl_drain", tbl_q.size(), 0);
    tbl_q.delete();
  endtask

  bit done = 0;

  // Independent random stream for the PERIOD=4, SYNC_FRAMES=1 instance.
  initial begin
    int kind, h;
    repeat (4) @(posedge clk);
    while (!done) begin
      kind = $urandom_range(0, 7);
      h    = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1 pwm4 = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'(i < h);
      end
    end
  end

  initial begin
    int nv, ne, kind, h, g;
    logic [15:0] pat;

    // Frames of 8 high: two to lock, then level 7 flat; final frame closes the last.
    for (int i = 0; i < 7; i++)
      vec_a.push_back('{high: 8, exp_v: (i >= 2 && i < 6), lvl: 7, trd: 0, trn: 0});
    // Full-high frames lock, then a descending and an ascending ramp.
    for (int i = 0; i < 3; i++)
      vec_b.push_back('{high: 16, exp_v: (i == 2), lvl: 15, trd: 0, trn: 0});
    for (int hh = 15; hh >= 1; hh--)
      vec_b.push_back('{high: hh, exp_v: 1, lvl: hh - 1, trd: 2, trn: 0});
    vec_b.push_back('{high: 1, exp_v: 1, lvl: 0, trd: 0, trn: 0});
    for (int hh = 2; hh <= 16; hh++)
      vec_b.push_back('{high: hh, exp_v: 1, lvl: hh - 1, trd: 1, trn: (hh == 2)});
    vec_b.push_back('{high: 16, exp_v: 0, lvl: 0, trd: 0, trn: 0});

    repeat (2) @(posedge clk);
    #2;
    check("reset_level",  level16,  0);
    check("reset_locked", locked16, 0);
    check("reset_valid",  valid16,  0);
    check("reset_trend",  trend16,  0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_table(vec_a);
    run_table(vec_b);

    // Glitch at frame offset 9 while locked at level 7, then relock.
    do_reset(0);
    repeat (4) send_frame16(8);
    ne = n_err16;
    send_pat16(16'h02FF);
    check("glitch_err_count", n_err16 - ne, 1);
    check("glitch_unlock", err_locked_snap, 0);
    check("glitch_level_held", err_level_snap, 7);
    send_frame16(8);
    send_frame16(8);
    check("relock_not_yet", locked16, 0);
    send_frame16(8);
    check("relock_done", locked16, 1);

    // Input stays low across a frame boundary.
    ne = n_err16;
    send_frame16(8);
    repeat (20) drive16(1'b0);
    check("low_err_count", n_err16 - ne, 1);
    check("low_unlock", locked16, 0);
    check("low_level_held", level16, 7);

    // Constant high input keeps lock at level 15 with no error.
    repeat (4) send_frame16(8);
    nv = n_valid16;
    ne = n_err16;
    repeat (80) drive16(1'b1);
    check("const_no_err", n_err16 - ne, 0);
    check("const_locked", locked16, 1);
    check("const_level", last_lvl16, 15);
    check("const_strobes", int'((n_valid16 - nv) >= 4), 1);
    repeat (20) drive16(1'b0);

    // Reset mid-frame while locked: outputs clear at once, strobes return after 2+1 frames.
    repeat (4) send_frame16(8);
    for (int i = 0; i < 11; i++) drive16(i < 8);
    do_reset(1);
    repeat (4) drive16(1'b0);
    nv = n_valid16;
    send_frame16(8);
    send_frame16(8);
    check("post_rst_no_strobe", n_valid16 - nv, 0);
    check("post_rst_unlocked", locked16, 0);
    send_frame16(8);
    check("post_rst_locked", locked16, 1);
    check("post_rst_still_none", n_valid16 - nv, 0);
    send_frame16(8);
    check("post_rst_first_strobe", n_valid16 - nv, 1);

    // Randomized frames against the model.
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 9);
      h    = $urandom_range(1, 16);
      pat  = '0;
      if (kind == 0) begin
        pat = '0;
      end else if (kind == 1) begin
        h = $urandom_range(1, 8);
        g = $urandom_range(h + 1, 15);
        for (int i = 0; i < 16; i++) pat[i] = (i < h) || (i == g);
      end else if (kind == 2) begin
        pat = 16'($urandom());
      end else begin
        for (int i = 0; i < 16; i++) pat[i] = (i < h);
      end
      send_pat16(pat);
    end
    repeat (20) drive16(1'b0);

    done = 1;
    repeat (8) @(posedge clk);
    check("d4_ever_strobed", int'(n_valid4 > 0), 1);
    check("d16_ever_strobed", int'(n_valid16 > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
